// File: rtl/banner_scroller.sv
// Scrolling 3-digit seven-segment banner: a 4-bit offset walks a 16-entry message ROM,
// three consecutive symbols are time-multiplexed onto active-low digit and segment lines.
module banner_scroller #(
  parameter int SCROLL_DIV  = 12000000,
  parameter int REFRESH_DIV = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       dir,
  input  logic       step,
  output logic [3:0] index,
  input  logic [4:0] value,
  output logic [2:0] an,
  output logic [7:0] seg
);

  localparam int RC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int SC_W = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;

  logic [3:0]      pos;
  logic [1:0]      sl;
  logic [RC_W-1:0] rc;
  logic [SC_W-1:0] sc;
  logic            rc_last;
  logic            sc_last;
  logic            tick;
  logic            adv;

  function automatic logic [7:0] seg_decode(input logic [4:0] v);
    logic [7:0] g;
    g = 8'hFF;
    if (!v[4]) begin
      case (v[3:0])
        4'h0: g = 8'hC0;
        4'h1: g = 8'hF9;
        4'h2: g = 8'hA4;
        4'h3: g = 8'hB0;
        4'h4: g = 8'h99;
        4'h5: g = 8'h92;
        4'h6: g = 8'h82;
        4'h7: g = 8'hF8;
        4'h8: g = 8'h80;
        4'h9: g = 8'h90;
        4'hA: g = 8'h88;
        4'hB: g = 8'h83;
        4'hC: g = 8'hC6;
        4'hD: g = 8'hA1;
        4'hE: g = 8'h86;
        default: g = 8'h8E;
      endcase
    end else if (v[3:0] == 4'h0) begin
      g = 8'hBF;
    end
    return g;
  endfunction

  // 4-bit add wraps naturally, so the window runs off the end of the ROM back to entry 0
  assign index   = pos + {2'b00, sl};
  assign rc_last = (rc == RC_W'(REFRESH_DIV - 1));
  assign sc_last = (sc == SC_W'(SCROLL_DIV - 1));
  assign tick    = enable & sc_last;
  assign adv     = tick | step;

  // Display refresh: an/seg reflect the slot and ROM data seen this cycle, one cycle late
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc  <= '0;
      sl  <= 2'd0;
      an  <= 3'b111;
      seg <= 8'hFF;
    end else begin
      an  <= (rc == '0) ? 3'b111 : ~(3'b001 << sl);
      seg <= seg_decode(value);
      if (rc_last) begin
        rc <= '0;
        sl <= (sl == 2'd2) ? 2'd0 : sl + 2'd1;
      end else begin
        rc <= rc + RC_W'(1);
      end
    end
  end

  // Scroll: sc only moves while enabled, so pausing keeps the partial interval
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc  <= '0;
      pos <= 4'd0;
    end else begin
      if (enable) sc <= sc_last ? '0 : sc + SC_W'(1);
      if (adv)    pos <= dir ? pos - 4'd1 : pos + 4'd1;
    end
  end

endmodule

// File: tb/tb_banner_scroller.sv
// Bench for banner_scroller: constant vector tables, directed corner sequences and a
// randomized run checked every cycle against a cycle-count based reference model.
module tb_banner_scroller;

  localparam int SD = 8;
  localparam int RD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       dir = 1'b0;
  logic       step = 1'b0;
  logic [3:0] index;
  logic [4:0] value;
  logic [2:0] an;
  logic [7:0] seg;

  logic [4:0] rom [16];
  int n_tests = 0;
  int n_fail  = 0;

  always_comb value = rom[index];

  banner_scroller #(.SCROLL_DIV(SD), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .step(step),
    .index(index), .value(value), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] ref_seg(input logic [4:0] v);
    if (!v[4]) return glyph[v[3:0]];
    if (v == 5'b10000) return 8'hBF;
    return 8'hFF;
  endfunction

  // Reference state: everything derives from cycles since reset and enabled cycles since reset
  int         cyc;
  int         en_cnt;
  int         m_pos;
  logic [2:0] m_an;
  logic [7:0] m_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc    = 0;
    en_cnt = 0;
    m_pos  = 0;
    m_an   = 3'b111;
    m_seg  = 8'hFF;
  endtask

  task automatic do_cycle();
    int  sl;
    int  rc;
    bit  adv;
    @(posedge clk);
    rc    = cyc % RD;
    sl    = (cyc / RD) % 3;
    m_an  = 3'b111;
    if (rc != 0) m_an[sl] = 1'b0;
    m_seg = ref_seg(rom[(m_pos + sl) % 16]);
    adv   = step || (enable && (en_cnt % SD) == SD - 1);
    if (enable) en_cnt++;
    if (adv) m_pos = dir ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
    cyc++;
    #1;
    check("index", 32'(index), 32'((m_pos + (cyc / RD) % 3) % 16));
    check("an", 32'(an), 32'(m_an));
    check("seg", 32'(seg), 32'(m_seg));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_an", 32'(an), 32'h7);
    check("rst_seg", 32'(seg), 32'hFF);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_index", 32'(index), 32'h0);
    check("rst_pos", 32'(dut.pos), 32'h0);
  endtask

  typedef struct {
    logic [4:0] v;
    logic [7:0] exp_seg;
  } dec_vec_t;

  dec_vec_t   dvec [12];
  logic [2:0] exp_an [6];
  logic [7:0] exp_sg [3];

  initial begin
    dvec[0]  = '{5'h00, 8'hC0};
    dvec[1]  = '{5'h05, 8'h92};
    dvec[2]  = '{5'h09, 8'h90};
    dvec[3]  = '{5'h0A, 8'h88};
    dvec[4]  = '{5'h0F, 8'h8E};
    dvec[5]  = '{5'h10, 8'hBF};
    dvec[6]  = '{5'h11, 8'hFF};
    dvec[7]  = '{5'h1F, 8'hFF};
    dvec[8]  = '{5'h07, 8'hF8};
    dvec[9]  = '{5'h0B, 8'h83};
    dvec[10] = '{5'h0D, 8'hA1};
    dvec[11] = '{5'h18, 8'hFF};
    exp_an   = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011};
    exp_sg   = '{8'hC0, 8'hF9, 8'hA4};

    for (int i = 0; i < 16; i++) rom[i] = 5'(i);
    model_reset();

    #1;
    do_reset();

    // Digit multiplexing with ROM returning its own address
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      do_cycle();
      check("refresh_an", 32'(an), 32'(exp_an[k]));
      if (k % 2 == 1) check("refresh_seg", 32'(seg), 32'(exp_sg[k / 2]));
    end

    // Decoder vectors: whole ROM holds one code so seg is that code's glyph
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 16; j++) rom[j] = dvec[k].v;
      do_cycle();
      check("decode", 32'(seg), 32'(dvec[k].exp_seg));
    end

    // Automatic scroll timing and wrap
    for (int j = 0; j < 16; j++) rom[j] = 5'h0;
    do_reset();
    enable = 1'b1;
    dir    = 1'b0;
    repeat (7) do_cycle();
    check("scroll_pre", 32'(dut.pos), 32'h0);
    do_cycle();
    check("scroll_1", 32'(dut.pos), 32'h1);
    repeat (112) do_cycle();
    check("scroll_15", 32'(dut.pos), 32'hF);
    repeat (8) do_cycle();
    check("scroll_wrap", 32'(dut.pos), 32'h0);

    // Backward step from 0
    do_reset();
    enable = 1'b0;
    dir    = 1'b1;
    step   = 1'b1;
    do_cycle();
    step   = 1'b0;
    check("back_pos", 32'(dut.pos), 32'hF);
    check("back_index", 32'(index), 32'hF);

    // Step coincident with tick, then pause/resume mid-interval
    do_reset();
    enable = 1'b1;
    dir    = 1'b0;
    repeat (7) do_cycle();
    step = 1'b1;
    do_cycle();
    step = 1'b0;
    check("step_tick", 32'(dut.pos), 32'h1);
    repeat (5) do_cycle();
    enable = 1'b0;
    repeat (4) do_cycle();
    check("paused", 32'(dut.pos), 32'h1);
    enable = 1'b1;
    repeat (2) do_cycle();
    check("resume_2", 32'(dut.pos), 32'h1);
    do_cycle();
    check("resume_3", 32'(dut.pos), 32'h2);
    enable = 1'b0;
    step   = 1'b1;
    repeat (5) do_cycle();
    step   = 1'b0;
    check("step_held", 32'(dut.pos), 32'h7);

    // Asynchronous reset between edges at pos=7 (seg shows C0 beforehand)
    #2;
    do_reset();
    do_cycle();

    // Randomized run, with occasional mid-scroll resets
    for (int n = 0; n < 900; n++) begin
      enable = ($urandom % 4) != 0;
      dir    = 1'($urandom % 2);
      step   = ($urandom % 8) == 0;
      if (n % 60 == 0)
        for (int j = 0; j < 16; j++) rom[j] = 5'($urandom % 32);
      if (n % 300 == 299) begin
        #2;
        do_reset();
      end
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
